vx_axi_read_mem_arb: RTL and testbench
======================================

// Module: VX_axi_read_mem_arb
// PURPOSE
// - Read-side counterpart of the AXI write arbiter: merges two AXI4 read masters (AR/R) onto one AXI4 read port.
// - Round-robin arbitrates AR requests and tags each output ARID with the winning input index.
// - Routes R beats back to the originating master by that tag, stripped off.
// - Sits between two cache/DMA read clients and the shared memory-side AXI port.
// PARAMETERS
// - AXI_DATA_WIDTH  512  R data width (bits); multiple of 8
// - AXI_ADDR_WIDTH  48   AR address width
// - AXI_TID_WIDTH   8    per-input ID width; output ID is AXI_TID_WIDTH+1
// - TAG_SEL_IDX     0    bit position of the inserted select bit in m_axi_arid/rid; 0..AXI_TID_WIDTH
// - MAX_PENDING     16   max outstanding read bursts per input; >=1
// PORTS
// - clk                                        in   1    clock
// - reset                                      in   1    asynchronous, active-high reset
// - m_axi_arvalid_N / m_axi_arready_N          in/out 1  input N (N=0,1) AR handshake
// - m_axi_ar{addr,id,len,size,burst,lock,cache,prot,qos,region}_N  in  ADDR/TID/8/3/2/2/4/3/4/4  input N AR fields
// - m_axi_rvalid_N / m_axi_rready_N            out/in 1  input N R handshake
// - m_axi_r{data,id,resp,last}_N               out  DATA/TID/2/1  input N R fields
// - m_axi_arvalid / m_axi_arready              out/in 1  output AR handshake
// - m_axi_arid                                 out  AXI_TID_WIDTH+1  tagged ID
// - m_axi_ar{addr,len,size,burst,lock,cache,prot,qos,region}  out  as inputs  forwarded AR fields
// - m_axi_rvalid / m_axi_rready                in/out 1  output R handshake
// - m_axi_rid                                  in   AXI_TID_WIDTH+1  tagged ID
// - m_axi_r{data,resp,last}                    in   DATA/2/1  R beat fields
// BEHAVIOUR
// - Reset (async assert, sync release)
//   - All *valid and *ready outputs are 0; output AR and R stages are empty.
//   - Pending counters are 0; round-robin priority is input 0.
// - AR path: a 1-entry registered stage.
//   - The stage loads when empty, or when draining (m_axi_arvalid & m_axi_arready) in the same cycle.
//   - Latency: input handshake at cycle T gives m_axi_arvalid=1 at T+1.
//   - Eligible input: arvalid_N=1 and pending_N<MAX_PENDING.
//   - Grant goes round-robin among eligible inputs; priority pointer moves past the winner on grant only.
//   - arready_N=1 only for the granted input in a loading cycle; never to both inputs.
//   - Fields are held stable while m_axi_arvalid=1 and m_axi_arready=0.
// - ID insert: m_axi_arid = {id[TID-1:TAG_SEL_IDX], N, id[TAG_SEL_IDX-1:0]}.
// - R path: a 1-entry registered stage.
//   - Destination N = m_axi_rid[TAG_SEL_IDX]; the bit is removed to form m_axi_rid_N.
//   - m_axi_rready = stage empty | (stage valid & rready of its destination); full throughput.
//   - Latency 1 cycle; rdata/rresp/rlast pass unmodified; interleaved beats of both inputs allowed.
// - Pending counters: width $clog2(MAX_PENDING+1).
//   - +1 on AR grant of N.
//   - -1 on delivered beat (rvalid_N & rready_N & rlast_N).
//   - Both in the same cycle: unchanged.
//   - An input at MAX_PENDING is ineligible until a decrement.
// - Errors: rlast delivered to N with pending_N==0 fires an assertion (sim only); counter saturates at 0.
// - Reset mid-burst: all state clears immediately; in-flight bursts are dropped; the memory side must share the reset.
// STRUCTURE
// - Shared package VX_axi_pkg: axi_ar_t and axi_r_t struct typedefs parameterised by widths; AXI_RESP_* constants.
// - One sub-module, VX_axi_pipe_reg: a 1-entry valid/ready register with flow-through on drain.
//   - Instantiated once for the AR stage and once for the R stage.
// - Arbiter and counters stay inline.
// TESTING
// - Both inputs assert arvalid every cycle, arready=1
//   -> grants alternate 0,1,0,1; arid[0] toggles; one AR per cycle after a 1-cycle fill.
// - Input 0 arid=0x5A, arlen=3
//   -> m_axi_arid=0x0B4 (TAG_SEL_IDX=0).
//   - Return 4 beats with rid=0x0B4 -> rid_0=0x5A, rlast on beat 4; rvalid_1 stays 0.
// - Stall m_axi_arready=0 for 5 cycles with both inputs pending
//   -> AR fields stable; exactly one arready_N pulse before the stall.
// - Input 1 issues 16 ARs with no R return
//   -> pending_1=16, arready_1 held 0, input 0 still granted.
//   - One rlast to input 1 -> input 1 granted again next eligible cycle.
// - Interleave R beats for 0 and 1; rready_0=0 for 3 cycles
//   -> m_axi_rready drops only while a beat for 0 is staged; no beat lost or reordered per ID.
// - Assert reset with 2 bursts in flight
//   -> all valids 0 same cycle; after release counters are 0 and input 0 has priority.

Source files
------------

// File: rtl/vx_axi_read_mem_arb_pkg.sv
// vx_axi_read_mem_arb_pkg: shared AXI constants, input-select enum and tag-mask helper
// for the two-master AXI read arbiter.
package vx_axi_read_mem_arb_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic {PORT_0 = 1'b0, PORT_1 = 1'b1} port_e;

    // Mask of the ID bits that sit below the inserted select bit.
    function automatic logic [63:0] lo_mask(input int idx);
        return (64'd1 << idx) - 64'd1;
    endfunction

endpackage

// File: rtl/vx_axi_read_mem_arb_pipe_reg.sv
// vx_axi_read_mem_arb_pipe_reg: 1-entry valid/ready register that accepts a new
// word in the same cycle its current word drains.
module vx_axi_read_mem_arb_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);
    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) r_data <= i_data;
        end
    end

endmodule

// File: rtl/vx_axi_read_mem_arb.sv
// vx_axi_read_mem_arb: merges two AXI4 read masters onto one read port; round-robin AR
// arbitration, input index inserted into ARID and used to route R beats back.
module vx_axi_read_mem_arb
    import vx_axi_read_mem_arb_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 512,
    parameter int AXI_ADDR_WIDTH = 48,
    parameter int AXI_TID_WIDTH  = 8,
    parameter int TAG_SEL_IDX    = 0,
    parameter int MAX_PENDING    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      m_axi_arvalid_0,
    output logic                      m_axi_arready_0,
    input  logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr_0,
    input  logic [AXI_TID_WIDTH-1:0]  m_axi_arid_0,
    input  logic [7:0]                m_axi_arlen_0,
    input  logic [2:0]                m_axi_arsize_0,
    input  logic [1:0]                m_axi_arburst_0,
    input  logic [1:0]                m_axi_arlock_0,
    input  logic [3:0]                m_axi_arcache_0,
    input  logic [2:0]                m_axi_arprot_0,
    input  logic [3:0]                m_axi_arqos_0,
    input  logic [3:0]                m_axi_arregion_0,
    output logic                      m_axi_rvalid_0,
    input  logic                      m_axi_rready_0,
    output logic [AXI_DATA_WIDTH-1:0] m_axi_rdata_0,
    output logic [AXI_TID_WIDTH-1:0]  m_axi_rid_0,
    output logic [1:0]                m_axi_rresp_0,
    output logic                      m_axi_rlast_0,
    input  logic                      m_axi_arvalid_1,
    output logic                      m_axi_arready_1,
    input  logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr_1,
    input  logic [AXI_TID_WIDTH-1:0]  m_axi_arid_1,
    input  logic [7:0]                m_axi_arlen_1,
    input  logic [2:0]                m_axi_arsize_1,
    input  logic [1:0]                m_axi_arburst_1,
    input  logic [1:0]                m_axi_arlock_1,
    input  logic [3:0]                m_axi_arcache_1,
    input  logic [2:0]                m_axi_arprot_1,
    input  logic [3:0]                m_axi_arqos_1,
    input  logic [3:0]                m_axi_arregion_1,
    output logic                      m_axi_rvalid_1,
    input  logic                      m_axi_rready_1,
    output logic [AXI_DATA_WIDTH-1:0] m_axi_rdata_1,
    output logic [AXI_TID_WIDTH-1:0]  m_axi_rid_1,
    output logic [1:0]                m_axi_rresp_1,
    output logic                      m_axi_rlast_1,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [AXI_TID_WIDTH:0]    m_axi_arid,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic [1:0]                m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic [3:0]                m_axi_arqos,
    output logic [3:0]                m_axi_arregion,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [AXI_TID_WIDTH:0]    m_axi_rid,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast
);
    localparam int T  = AXI_TID_WIDTH;
    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam logic [T:0]    LO   = (T+1)'(lo_mask(TAG_SEL_IDX));
    localparam logic [CW-1:0] MAXP = CW'(MAX_PENDING);

    typedef struct packed {
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [T:0]                id;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
        logic [1:0]                lock;
        logic [3:0]                cache;
        logic [2:0]                prot;
        logic [3:0]                qos;
        logic [3:0]                region;
    } ar_t;

    typedef struct packed {
        logic                      dest;
        logic [T-1:0]              id;
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [1:0]                resp;
        logic                      last;
    } r_t;

    ar_t           w_ar_in, w_ar_out;
    r_t            w_r_in, w_r_out;
    logic          w_ar_load_ok, w_ar_ld, w_sel, w_r_ok, w_rv, w_r_dst_rdy;
    logic [1:0]    w_elig, w_arready, w_dec;
    logic [T:0]    w_id_ext;
    port_e         r_prio, w_win;
    logic [CW-1:0] r_pend [2];

    // An input stuck at MAX_PENDING drops out of arbitration until a burst completes.
    always_comb begin
        w_elig    = {m_axi_arvalid_1 && r_pend[1] < MAXP, m_axi_arvalid_0 && r_pend[0] < MAXP};
        w_win     = w_elig[r_prio] ? r_prio : (r_prio == PORT_0 ? PORT_1 : PORT_0);
        w_sel     = w_win == PORT_1;
        w_ar_ld   = |w_elig && w_ar_load_ok && !reset;
        w_arready = w_ar_ld ? (w_sel ? 2'b10 : 2'b01) : 2'b00;
        w_id_ext  = {1'b0, w_sel ? m_axi_arid_1 : m_axi_arid_0};
        w_ar_in.addr   = w_sel ? m_axi_araddr_1   : m_axi_araddr_0;
        w_ar_in.id     = ((w_id_ext & ~LO) << 1) | ((T+1)'(w_sel) << TAG_SEL_IDX) | (w_id_ext & LO);
        w_ar_in.len    = w_sel ? m_axi_arlen_1    : m_axi_arlen_0;
        w_ar_in.size   = w_sel ? m_axi_arsize_1   : m_axi_arsize_0;
        w_ar_in.burst  = w_sel ? m_axi_arburst_1  : m_axi_arburst_0;
        w_ar_in.lock   = w_sel ? m_axi_arlock_1   : m_axi_arlock_0;
        w_ar_in.cache  = w_sel ? m_axi_arcache_1  : m_axi_arcache_0;
        w_ar_in.prot   = w_sel ? m_axi_arprot_1   : m_axi_arprot_0;
        w_ar_in.qos    = w_sel ? m_axi_arqos_1    : m_axi_arqos_0;
        w_ar_in.region = w_sel ? m_axi_arregion_1 : m_axi_arregion_0;
    end

    assign m_axi_arready_0 = w_arready[0];
    assign m_axi_arready_1 = w_arready[1];

    vx_axi_read_mem_arb_pipe_reg #(.W($bits(ar_t))) u_ar_stage (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_ar_ld),
        .o_ready (w_ar_load_ok),
        .i_data  (w_ar_in),
        .o_valid (m_axi_arvalid),
        .i_ready (m_axi_arready),
        .o_data  (w_ar_out)
    );

    assign m_axi_araddr   = w_ar_out.addr;
    assign m_axi_arid     = w_ar_out.id;
    assign m_axi_arlen    = w_ar_out.len;
    assign m_axi_arsize   = w_ar_out.size;
    assign m_axi_arburst  = w_ar_out.burst;
    assign m_axi_arlock   = w_ar_out.lock;
    assign m_axi_arcache  = w_ar_out.cache;
    assign m_axi_arprot   = w_ar_out.prot;
    assign m_axi_arqos    = w_ar_out.qos;
    assign m_axi_arregion = w_ar_out.region;

    // The select bit picks the destination and is squeezed out of the returned ID.
    assign w_r_in.dest = m_axi_rid[TAG_SEL_IDX];
    assign w_r_in.id   = T'(((m_axi_rid >> 1) & ~LO) | (m_axi_rid & LO));
    assign w_r_in.data = m_axi_rdata;
    assign w_r_in.resp = m_axi_rresp;
    assign w_r_in.last = m_axi_rlast;
    assign w_r_dst_rdy = w_r_out.dest ? m_axi_rready_1 : m_axi_rready_0;
    assign m_axi_rready = w_r_ok && !reset;

    vx_axi_read_mem_arb_pipe_reg #(.W($bits(r_t))) u_r_stage (
        .clk     (clk),
        .reset   (reset),
        .i_valid (m_axi_rvalid),
        .o_ready (w_r_ok),
        .i_data  (w_r_in),
        .o_valid (w_rv),
        .i_ready (w_r_dst_rdy),
        .o_data  (w_r_out)
    );

    assign m_axi_rvalid_0 = w_rv && !w_r_out.dest;
    assign m_axi_rvalid_1 = w_rv && w_r_out.dest;
    assign m_axi_rdata_0  = w_r_out.data;
    assign m_axi_rdata_1  = w_r_out.data;
    assign m_axi_rid_0    = w_r_out.id;
    assign m_axi_rid_1    = w_r_out.id;
    assign m_axi_rresp_0  = w_r_out.resp;
    assign m_axi_rresp_1  = w_r_out.resp;
    assign m_axi_rlast_0  = w_r_out.last;
    assign m_axi_rlast_1  = w_r_out.last;
    assign w_dec = {m_axi_rvalid_1 && m_axi_rready_1 && w_r_out.last,
                    m_axi_rvalid_0 && m_axi_rready_0 && w_r_out.last};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend[0] <= '0;
            r_pend[1] <= '0;
            r_prio    <= PORT_0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_arready[i] && !w_dec[i]) r_pend[i] <= r_pend[i] + CW'(1);
                else if (w_dec[i] && !w_arready[i] && r_pend[i] != '0) r_pend[i] <= r_pend[i] - CW'(1);
            end
            if (w_ar_ld) r_prio <= w_sel ? PORT_0 : PORT_1;
        end
    end

    a_no_underflow_0: assert property (@(posedge clk) disable iff (reset) !(w_dec[0] && r_pend[0] == '0));
    a_no_underflow_1: assert property (@(posedge clk) disable iff (reset) !(w_dec[1] && r_pend[1] == '0));

endmodule

// File: tb/tb_vx_axi_read_mem_arb.sv
// tb_vx_axi_read_mem_arb: directed stimulus with a queue-level reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_vx_axi_read_mem_arb;
    localparam int DW = 32, AW = 48, TW = 8, MAXP = 16;

    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    logic          arvalid0 = 0, arvalid1 = 0, rready0 = 1, rready1 = 1;
    logic [AW-1:0] araddr0 = 0, araddr1 = 0;
    logic [TW-1:0] arid0 = 0, arid1 = 0;
    logic [7:0]    arlen0 = 0, arlen1 = 0;
    logic          m_arready = 1, m_rvalid = 0, m_rlast = 0;
    logic [TW:0]   m_rid = 0;
    logic [DW-1:0] m_rdata = 0;
    logic          arready_0, arready_1, rvalid_0, rvalid_1, rlast_0, rlast_1;
    logic [DW-1:0] rdata_0, rdata_1;
    logic [TW-1:0] rid_0, rid_1;
    logic [1:0]    rresp_0, rresp_1, o_arburst, o_arlock;
    logic          o_arvalid, o_rready;
    logic [AW-1:0] o_araddr;
    logic [TW:0]   o_arid;
    logic [7:0]    o_arlen;
    logic [2:0]    o_arsize, o_arprot;
    logic [3:0]    o_arcache, o_arqos, o_arregion;

    vx_axi_read_mem_arb #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_TID_WIDTH(TW),
                          .TAG_SEL_IDX(0), .MAX_PENDING(MAXP)) dut (
        .clk(clk), .reset(reset),
        .m_axi_arvalid_0(arvalid0), .m_axi_arready_0(arready_0), .m_axi_araddr_0(araddr0),
        .m_axi_arid_0(arid0), .m_axi_arlen_0(arlen0), .m_axi_arsize_0(3'd2), .m_axi_arburst_0(2'd1),
        .m_axi_arlock_0(2'd0), .m_axi_arcache_0(4'h3), .m_axi_arprot_0(3'd0), .m_axi_arqos_0(4'd0),
        .m_axi_arregion_0(4'd0), .m_axi_rvalid_0(rvalid_0), .m_axi_rready_0(rready0),
        .m_axi_rdata_0(rdata_0), .m_axi_rid_0(rid_0), .m_axi_rresp_0(rresp_0), .m_axi_rlast_0(rlast_0),
        .m_axi_arvalid_1(arvalid1), .m_axi_arready_1(arready_1), .m_axi_araddr_1(araddr1),
        .m_axi_arid_1(arid1), .m_axi_arlen_1(arlen1), .m_axi_arsize_1(3'd2), .m_axi_arburst_1(2'd1),
        .m_axi_arlock_1(2'd0), .m_axi_arcache_1(4'hA), .m_axi_arprot_1(3'd0), .m_axi_arqos_1(4'd0),
        .m_axi_arregion_1(4'd0), .m_axi_rvalid_1(rvalid_1), .m_axi_rready_1(rready1),
        .m_axi_rdata_1(rdata_1), .m_axi_rid_1(rid_1), .m_axi_rresp_1(rresp_1), .m_axi_rlast_1(rlast_1),
        .m_axi_arvalid(o_arvalid), .m_axi_arready(m_arready), .m_axi_araddr(o_araddr),
        .m_axi_arid(o_arid), .m_axi_arlen(o_arlen), .m_axi_arsize(o_arsize), .m_axi_arburst(o_arburst),
        .m_axi_arlock(o_arlock), .m_axi_arcache(o_arcache), .m_axi_arprot(o_arprot),
        .m_axi_arqos(o_arqos), .m_axi_arregion(o_arregion),
        .m_axi_rvalid(m_rvalid), .m_axi_rready(o_rready), .m_axi_rid(m_rid),
        .m_axi_rdata(m_rdata), .m_axi_rresp(2'b00), .m_axi_rlast(m_rlast)
    );

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    typedef struct {logic [TW:0] id; logic [AW-1:0] addr; logic [7:0] len; logic [3:0] cache;} ar_e;
    typedef struct {logic dest; logic [TW-1:0] id; logic [DW-1:0] data; logic last;} r_e;
    ar_e arq[$];
    r_e  rq[$];
    int  pend[2];
    int  prio = 0;
    int  gnt_log[$];
    logic [DW-1:0] got0[$], got1[$];
    logic          gl0[$];
    logic el0, el1, m_ev, m_drain, m_ld, m_rv, m_dst, m_dlv, m_mr;
    int   m_win;

    // Reference model: an AR queue of depth one, round-robin over eligible inputs,
    // outstanding-burst counts, and an R queue of depth one routed by the low ID bit.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_arvalid", o_arvalid, 0);
            chk("rst_arready", {arready_1, arready_0}, 0);
            chk("rst_rvalid", {rvalid_1, rvalid_0}, 0);
            chk("rst_rready", o_rready, 0);
            arq.delete(); rq.delete(); pend[0] = 0; pend[1] = 0; prio = 0;
        end else begin
            m_ev = arq.size() != 0;
            chk("arvalid", o_arvalid, m_ev);
            if (m_ev) begin
                chk("arid", o_arid, arq[0].id);
                chk("araddr", o_araddr, arq[0].addr);
                chk("arlen", o_arlen, arq[0].len);
                chk("arcache", o_arcache, arq[0].cache);
            end
            m_drain = m_ev && m_arready;
            m_ld = !m_ev || m_drain;
            el0 = arvalid0 && pend[0] < MAXP;
            el1 = arvalid1 && pend[1] < MAXP;
            if (prio == 0) m_win = el0 ? 0 : el1 ? 1 : -1;
            else m_win = el1 ? 1 : el0 ? 0 : -1;
            if (!m_ld) m_win = -1;
            chk("arready_0", arready_0, m_win == 0);
            chk("arready_1", arready_1, m_win == 1);
            m_rv = rq.size() != 0;
            m_dst = m_rv ? rq[0].dest : 1'b0;
            chk("rvalid_0", rvalid_0, m_rv && !m_dst);
            chk("rvalid_1", rvalid_1, m_rv && m_dst);
            if (m_rv) begin
                chk("rid", m_dst ? rid_1 : rid_0, rq[0].id);
                chk("rdata", m_dst ? rdata_1 : rdata_0, rq[0].data);
                chk("rlast", m_dst ? rlast_1 : rlast_0, rq[0].last);
                chk("rresp", m_dst ? rresp_1 : rresp_0, 0);
            end
            m_dlv = m_rv && (m_dst ? rready1 : rready0);
            m_mr = !m_rv || m_dlv;
            chk("m_rready", o_rready, m_mr);
            if (m_drain) void'(arq.pop_front());
            if (m_win >= 0) begin
                gnt_log.push_back(m_win);
                if (m_win == 0) arq.push_back('{id: {arid0, 1'b0}, addr: araddr0, len: arlen0, cache: 4'h3});
                else arq.push_back('{id: {arid1, 1'b1}, addr: araddr1, len: arlen1, cache: 4'hA});
                pend[m_win]++;
                prio = 1 - m_win;
            end
            if (m_dlv) begin
                if (m_dst) got1.push_back(rq[0].data);
                else begin got0.push_back(rq[0].data); gl0.push_back(rq[0].last); end
                if (rq[0].last && pend[m_dst] > 0) pend[m_dst]--;
                void'(rq.pop_front());
            end
            if (m_rvalid && m_mr) rq.push_back('{dest: m_rid[0], id: m_rid[TW:1], data: m_rdata, last: m_rlast});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_ar(input int n0, input int n1);
        int c0 = 0, c1 = 0, cyc = 0;
        logic h0, h1;
        arvalid0 = n0 > 0;
        arvalid1 = n1 > 0;
        while ((c0 < n0 || c1 < n1) && cyc < 200) begin
            @(negedge clk);
            h0 = arvalid0 && arready_0;
            h1 = arvalid1 && arready_1;
            tick();
            cyc++;
            if (h0) begin c0++; araddr0 += 64; if (c0 >= n0) arvalid0 = 0; end
            if (h1) begin c1++; araddr1 += 64; if (c1 >= n1) arvalid1 = 0; end
        end
        chk("run_ar_done", {c0 >= n0, c1 >= n1}, 2'b11);
        arvalid0 = 0;
        arvalid1 = 0;
    endtask

    task automatic send_r(input logic [TW:0] id, input logic [DW-1:0] d, input logic last);
        logic hs = 0;
        int cyc = 0;
        m_rvalid = 1; m_rid = id; m_rdata = d; m_rlast = last;
        while (!hs && cyc < 50) begin
            @(negedge clk);
            hs = o_rready;
            tick();
            cyc++;
        end
        chk("send_r_accepted", hs, 1);
        m_rvalid = 0;
    endtask

    function automatic int count_g(input int who);
        int n = 0;
        foreach (gnt_log[i]) if (gnt_log[i] == who) n++;
        return n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        reset = 0;
        // Both inputs request every cycle: grants alternate starting at input 0.
        arid0 = 8'h10; arid1 = 8'h21; araddr0 = 48'h1000; araddr1 = 48'h2000;
        gnt_log.delete();
        run_ar(4, 4);
        chk("alt_count", gnt_log.size(), 8);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++) chk("alt_order", gnt_log[i], i % 2);
        repeat (2) tick();
        // Interleaved R beats, input 0 back-pressures for 3 cycles.
        got0.delete(); got1.delete();
        rready0 = 0;
        fork
            for (int i = 0; i < 8; i++) send_r(i % 2 ? {arid1, 1'b1} : {arid0, 1'b0}, DW'(100 + i), 1'b1);
            begin repeat (3) tick(); rready0 = 1; end
        join
        repeat (3) tick();
        chk("ilv_n0", got0.size(), 4);
        chk("ilv_n1", got1.size(), 4);
        for (int i = 0; i < 4 && i < got0.size(); i++) chk("ilv_d0", got0[i], 100 + 2 * i);
        for (int i = 0; i < 4 && i < got1.size(); i++) chk("ilv_d1", got1[i], 101 + 2 * i);
        // ID 0x5A from input 0 is tagged to 0x0B4; a 4-beat burst comes back stripped.
        arid0 = 8'h5A; arlen0 = 8'd3;
        run_ar(1, 0);
        chk("arid_5a_valid", o_arvalid, 1);
        chk("arid_5a", o_arid, 9'h0B4);
        arlen0 = 0;
        got0.delete(); gl0.delete();
        send_r(9'h0B4, 32'h300, 1'b0);
        chk("rid0_5a_valid", rvalid_0, 1);
        chk("rid0_5a", rid_0, 8'h5A);
        for (int i = 1; i < 4; i++) send_r(9'h0B4, DW'(32'h300 + i), 1'(i == 3));
        repeat (2) tick();
        chk("burst_beats", got0.size(), 4);
        for (int i = 0; i < 4 && i < gl0.size(); i++) chk("burst_last", gl0[i], i == 3);
        // Output stall: exactly one grant (input 1, it holds priority) and stable fields.
        arid0 = 8'h33; arid1 = 8'h44;
        m_arready = 0; arvalid0 = 1; arvalid1 = 1;
        gnt_log.delete();
        for (int k = 0; k < 5; k++) begin
            logic h1;
            @(negedge clk);
            if (k > 0) chk("stall_arid", o_arid, 9'h089);
            h1 = arvalid1 && arready_1;
            tick();
            if (h1) arvalid1 = 0;
        end
        chk("stall_gnt_n", gnt_log.size(), 1);
        if (gnt_log.size() > 0) chk("stall_gnt_who", gnt_log[0], 1);
        m_arready = 1;
        run_ar(1, 0);
        repeat (2) tick();
        send_r({8'h44, 1'b1}, 32'd1, 1'b1);
        send_r({8'h33, 1'b0}, 32'd2, 1'b1);
        repeat (2) tick();
        // Input 1 saturates at MAX_PENDING; input 0 keeps being served.
        arid1 = 8'h77;
        run_ar(0, MAXP);
        gnt_log.delete();
        arvalid0 = 1; arvalid1 = 1;
        repeat (5) tick();
        arvalid0 = 0;
        chk("sat_gnt1", count_g(1), 0);
        chk("sat_gnt0", count_g(0), 5);
        gnt_log.delete();
        send_r({8'h77, 1'b1}, 32'd9, 1'b1);
        repeat (4) tick();
        arvalid1 = 0;
        chk("sat_release", count_g(1), 1);
        repeat (2) tick();
        // Reset with an AR and an R beat parked in the stages.
        m_arready = 0; rready0 = 0; arvalid0 = 1;
        m_rvalid = 1; m_rid = {8'h5A, 1'b0}; m_rdata = 32'hDEAD; m_rlast = 1;
        tick();
        m_rvalid = 0; arvalid1 = 1;
        tick();
        chk("pre_rst_arvalid", o_arvalid, 1);
        chk("pre_rst_rvalid0", rvalid_0, 1);
        #1 reset = 1;
        #1;
        chk("async_arvalid", o_arvalid, 0);
        chk("async_rvalid0", rvalid_0, 0);
        chk("async_arready", {arready_1, arready_0}, 0);
        chk("async_rready", o_rready, 0);
        arvalid0 = 0; arvalid1 = 0; rready0 = 1; m_arready = 1;
        repeat (2) tick();
        reset = 0;
        gnt_log.delete();
        run_ar(2, 2);
        if (gnt_log.size() > 1) begin
            chk("post_rst_first", gnt_log[0], 0);
            chk("post_rst_second", gnt_log[1], 1);
        end else chk("post_rst_gnts", gnt_log.size(), 4);
        run_ar(0, MAXP - 2);
        gnt_log.delete();
        arvalid1 = 1;
        repeat (3) tick();
        arvalid1 = 0;
        chk("post_rst_full", count_g(1), 0);
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
